// File: rtl/enc_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_dec_pkg
// Description : Shared widths and occupancy encodings for the encoder/decoder
//               stream link.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_dec_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 1 << CODE_W;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
// Module      : skid_buf2
// Description : Two-entry in-order skid buffer. The head entry drives the
//               output directly from a register.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buf2
  import enc_dec_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output occ_state_e       o_state
);

  occ_state_e       r_state;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  // The caller never pushes while FULL, so that case only handles the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (i_push) begin
            r_head  <= i_data;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (i_push && i_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_tail  <= i_data;
            r_state <= ST_FULL;
          end else if (i_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (i_pop) begin
            r_head  <= r_tail;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/decoder_3x8_stream.sv
`default_nettype none
// ============================================================================
// Module      : decoder_3x8_stream
// Description : Streaming 3-to-8 decoder with two-entry skid buffer and a
//               saturating null-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_3x8_stream
  import enc_dec_pkg::occ_state_e, enc_dec_pkg::ST_EMPTY, enc_dec_pkg::ST_FULL;
#(
  parameter int CODE_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CODE_W:0]       in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<CODE_W)-1:0] out_data,
  output logic                  out_null,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      null_cnt
);

  localparam int OUT_W = 1 << CODE_W;

  occ_state_e       w_state;
  logic             w_accept;
  logic             w_pop;
  logic             w_act;
  logic [OUT_W:0]   w_din;
  logic [OUT_W:0]   w_dout;
  logic [CNT_W-1:0] r_null_cnt;

  assign in_ready  = en & (w_state != ST_FULL) & ~rst;
  assign out_valid = (w_state != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_act     = in_code[CODE_W];

  // Decoded word stored as {null, one-hot data}; a null word carries no bits.
  assign w_din = w_act ? {1'b0, OUT_W'(1) << in_code[CODE_W-1:0]}
                       : {1'b1, {OUT_W{1'b0}}};

  skid_buf2 #(
    .WIDTH (OUT_W + 1)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_data  (w_din),
    .o_data  (w_dout),
    .o_state (w_state)
  );

  assign out_null = w_dout[OUT_W];
  assign out_data = w_dout[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_null_cnt <= '0;
    end else if (w_accept && !w_act && (r_null_cnt != {CNT_W{1'b1}})) begin
      r_null_cnt <= r_null_cnt + CNT_W'(1);
    end
  end

  assign null_cnt = r_null_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3x8_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_3x8_stream
// Description : Directed scoreboard bench for decoder_3x8_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_3x8_stream;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, out_ready, cnt_clr;
  logic [3:0] in_code;
  logic       in_ready, out_valid, out_null;
  logic [7:0] out_data, null_cnt;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [8:0] q[$];
  logic [7:0] m_cnt = 8'd0;

  always #5 clk = ~clk;

  decoder_3x8_stream dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_null  (out_null),
    .cnt_clr   (cnt_clr),
    .null_cnt  (null_cnt)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic step();
    logic       acc, pp;
    logic [8:0] exp_word;
    @(negedge clk);
    check("in_ready", 16'(in_ready), 16'(en & (q.size() < 2) & ~rst));
    check("out_valid", 16'(out_valid), 16'(q.size() != 0));
    check("null_cnt", 16'(null_cnt), 16'(m_cnt));
    if (q.size() != 0) begin
      check("out_data", 16'(out_data), 16'(q[0][7:0]));
      check("out_null", 16'(out_null), 16'(q[0][8]));
    end
    acc      = in_valid & en & (q.size() < 2) & ~rst;
    pp       = (q.size() != 0) & out_ready;
    exp_word = in_code[3] ? {1'b0, 8'h01 << in_code[2:0]} : 9'h100;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cnt = 8'd0;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(exp_word);
      if (cnt_clr) m_cnt = 8'd0;
      else if (acc && !in_code[3] && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cnt_clr = 1'b0; in_code = 4'b0000;
    step();

    // Fill to FULL, then reset over two cycles
    rst = 1'b0; in_valid = 1'b1; in_code = 4'b1011; step();
    in_code = 4'b0000; step();
    in_valid = 1'b0; step();
    rst = 1'b1; repeat (2) step();
    rst = 1'b0;
    check("rst_out_data", 16'(out_data), 16'h0000);
    check("rst_out_valid", 16'(out_valid), 16'h0000);
    step();

    // Sweep every index back-to-back
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_code = 4'(8 + i);
      step();
    end
    drain();

    // Single null word
    in_valid = 1'b1; in_code = 4'b0101; step();
    drain();

    // Counter saturation, then clear colliding with a null accept
    in_valid = 1'b1; in_code = 4'b0000;
    repeat (256) step();
    in_valid = 1'b0; step();
    check("cnt_sat", 16'(null_cnt), 16'h00FF);
    in_valid = 1'b1; cnt_clr = 1'b1; step();
    cnt_clr = 1'b0; in_valid = 1'b0; step();
    check("cnt_clr", 16'(null_cnt), 16'h0000);
    drain();

    // Back-pressure into FULL, then ordered drain
    out_ready = 1'b0; in_valid = 1'b1;
    in_code = 4'b1011; step();
    in_code = 4'b1110; step();
    in_code = 4'b1111; step();
    step();
    check("bp_hold", 16'(out_data), 16'h0008);
    drain();

    // Accept and pop in the same cycle while ONE
    out_ready = 1'b0; in_valid = 1'b1; in_code = 4'b1100; step();
    out_ready = 1'b1; in_code = 4'b1001; step();
    in_valid = 1'b0; out_ready = 1'b0; step();
    check("simul_head", 16'(out_data), 16'h0002);
    drain();

    // Enable low blocks new words while buffered ones still drain
    out_ready = 1'b0; in_valid = 1'b1; in_code = 4'b1010; step();
    en = 1'b0; in_code = 4'b1111; repeat (2) step();
    out_ready = 1'b1; repeat (3) step();
    check("en_empty", 16'(out_valid), 16'h0000);
    en = 1'b1; drain();

    check("sb_empty", 16'(q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
